// File: rtl/pingpong_row_buffer_pkg.sv
// Shared defaults and width helpers for the ping-pong row buffer.
// Bank geometry defaults plus the pointer and length width rules.
package pingpong_row_buffer_pkg;

  localparam int unsigned DEF_WORD_W        = 32;
  localparam int unsigned DEF_WORDS_PER_ROW = 5;
  localparam int unsigned DEF_DEPTH         = 50;

  // Index width for a pointer over n positions; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a word count that must hold values 0..cap inclusive.
  function automatic int unsigned len_w(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/pingpong_row_buffer_row_bank.sv
// One storage bank: DEPTH rows of WORDS_PER_ROW words.
// Synchronous single-word write port and a combinational word read mux.
module pingpong_row_buffer_row_bank
  import pingpong_row_buffer_pkg::*;
#(
  parameter int unsigned WORD_W        = DEF_WORD_W,
  parameter int unsigned WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned WI_W          = ptr_w(WORDS_PER_ROW),
  parameter int unsigned RI_W          = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RI_W-1:0]   ri,
  input  logic [WI_W-1:0]   wi,
  input  logic [WORD_W-1:0] data,
  input  logic [RI_W-1:0]   rr,
  input  logic [WI_W-1:0]   rw,
  output logic [WORD_W-1:0] q
);

  logic [WORDS_PER_ROW-1:0][WORD_W-1:0] mem_r [DEPTH];

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[ri][wi] <= data;
    end
  end

  assign q = mem_r[rr][rw];

endmodule

// File: rtl/pingpong_row_buffer.sv
// Ping-pong staging buffer: one bank fills while the other drains in arrival order.
// Holds write/read pointers, per-bank full flags and lengths, and both handshakes.
module pingpong_row_buffer
  import pingpong_row_buffer_pkg::*;
#(
  parameter int unsigned WORD_W        = DEF_WORD_W,
  parameter int unsigned WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int unsigned DEPTH         = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              out_bank
);

  localparam int unsigned CAP   = DEPTH * WORDS_PER_ROW;
  localparam int unsigned WI_W  = ptr_w(WORDS_PER_ROW);
  localparam int unsigned RI_W  = ptr_w(DEPTH);
  localparam int unsigned LEN_W = len_w(CAP);

  localparam logic [WI_W-1:0]  WI_LAST = WI_W'(WORDS_PER_ROW - 1);
  localparam logic [LEN_W-1:0] CAP_M1  = LEN_W'(CAP - 1);

  logic             wr_bank_r;
  logic             rd_bank_r;
  logic [1:0]       full_r;
  logic [1:0]       full_nxt_s;
  logic [LEN_W-1:0] len_r [2];
  logic [WI_W-1:0]  wi_r;
  logic [RI_W-1:0]  ri_r;
  logic [LEN_W-1:0] wcnt_r;
  logic [WI_W-1:0]  rw_r;
  logic [RI_W-1:0]  rr_r;
  logic [LEN_W-1:0] rcnt_r;

  logic              wr_fire_s;
  logic              close_s;
  logic              rd_fire_s;
  logic              rd_done_s;
  logic              out_last_s;
  logic [1:0]        we_s;
  logic [WORD_W-1:0] rd_data_s [2];

  assign in_ready   = ~full_r[wr_bank_r];
  assign out_valid  = full_r[rd_bank_r];
  assign out_bank   = rd_bank_r;
  assign out_last_s = full_r[rd_bank_r] & ((rcnt_r + 1'b1) == len_r[rd_bank_r]);
  assign out_last   = out_last_s;
  assign out_data   = rd_data_s[rd_bank_r];

  assign wr_fire_s = in_valid & ~full_r[wr_bank_r];
  // Capacity close and in_last close on the same word collapse into one close.
  assign close_s   = wr_fire_s & (in_last | (wcnt_r == CAP_M1));
  assign rd_fire_s = full_r[rd_bank_r] & out_ready;
  assign rd_done_s = rd_fire_s & out_last_s;
  assign we_s      = {wr_fire_s & wr_bank_r, wr_fire_s & ~wr_bank_r};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_row_buffer_row_bank #(
      .WORD_W        (WORD_W),
      .WORDS_PER_ROW (WORDS_PER_ROW),
      .DEPTH         (DEPTH),
      .WI_W          (WI_W),
      .RI_W          (RI_W)
    ) u_row_bank (
      .clk  (clk),
      .we   (we_s[b]),
      .ri   (ri_r),
      .wi   (wi_r),
      .data (in_data),
      .rr   (rr_r),
      .rw   (rw_r),
      .q    (rd_data_s[b])
    );
  end

  // Next full flags; writer never targets a full bank, so the two updates touch different banks.
  always_comb begin
    full_nxt_s = full_r;
    if (close_s) begin
      full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
    end
    if (rd_done_s) begin
      full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
    end
  end

  // Pointer, bank-select, length and full-flag state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      full_r    <= 2'b00;
      len_r[0]  <= '0;
      len_r[1]  <= '0;
      wi_r      <= '0;
      ri_r      <= '0;
      wcnt_r    <= '0;
      rw_r      <= '0;
      rr_r      <= '0;
      rcnt_r    <= '0;
    end else begin
      full_r <= full_nxt_s;
      if (close_s) begin
        len_r[wr_bank_r] <= wcnt_r + 1'b1;
        wr_bank_r        <= ~wr_bank_r;
        wi_r             <= '0;
        ri_r             <= '0;
        wcnt_r           <= '0;
      end else if (wr_fire_s) begin
        wcnt_r <= wcnt_r + 1'b1;
        if (wi_r == WI_LAST) begin
          wi_r <= '0;
          ri_r <= ri_r + 1'b1;
        end else begin
          wi_r <= wi_r + 1'b1;
        end
      end
      if (rd_done_s) begin
        rd_bank_r <= ~rd_bank_r;
        rw_r      <= '0;
        rr_r      <= '0;
        rcnt_r    <= '0;
      end else if (rd_fire_s) begin
        rcnt_r <= rcnt_r + 1'b1;
        if (rw_r == WI_LAST) begin
          rw_r <= '0;
          rr_r <= rr_r + 1'b1;
        end else begin
          rw_r <= rw_r + 1'b1;
        end
      end
    end
  end

endmodule
